// File: rtl/switchbox_config_loader.sv
// -----------------------------------------------------------------------------
// switchbox_config_loader
//
// Serial configuration loader for one switch-box tile. Bits arrive under a
// valid strobe, are assembled LSB-first in a shift register and, once a full
// word is in, are copied to the config_out shadow register in a single edge.
// The switch box therefore never routes on a partially loaded configuration.
//
// Optional feature macro: SWITCHBOX_CONFIG_PARITY_EN
//   defined   : one trailing even-parity bit per load is checked. A mismatch
//               sets the sticky cfg_error flag and discards the load.
//   undefined : a load commits directly after CONFIG_WIDTH bits. cfg_error = 0.
//
// Ports
//   clock         : single clock, rising edge
//   reset         : synchronous, active-high reset
//   cfg_start     : pulse that begins or restarts a load
//   cfg_bit_in    : serial configuration bit
//   cfg_bit_valid : cfg_bit_in is valid this cycle
//   config_out    : committed configuration (to switch box config_in)
//   cfg_busy      : a load is in progress (registered)
//   cfg_done      : one-cycle pulse when a commit completes
//   cfg_error     : sticky parity-failure flag (parity build only)
// -----------------------------------------------------------------------------
module switchbox_config_loader #(
    parameter int CONFIG_WIDTH = 264,
    parameter int CNT_WIDTH    = $clog2(CONFIG_WIDTH)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cfg_start,
    input  logic                    cfg_bit_in,
    input  logic                    cfg_bit_valid,
    output logic [CONFIG_WIDTH-1:0] config_out,
    output logic                    cfg_busy,
    output logic                    cfg_done,
    output logic                    cfg_error
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
`ifdef SWITCHBOX_CONFIG_PARITY_EN
        PARITY = 2'd2,
`endif
        COMMIT = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(CONFIG_WIDTH - 1);

    state_t                  state_q, state_d;
    logic [CONFIG_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    commit;
`ifdef SWITCHBOX_CONFIG_PARITY_EN
    logic                    par_q, par_d;
    logic                    err_set;
`endif

    // Next-state and datapath logic.
    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
`ifdef SWITCHBOX_CONFIG_PARITY_EN
        par_d   = par_q;
        err_set = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // Valid bits are ignored here; a start wins over a same-cycle bit.
                if (cfg_start) begin
                    shift_d = '0;
                    cnt_d   = '0;
`ifdef SWITCHBOX_CONFIG_PARITY_EN
                    par_d   = 1'b0;
`endif
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cfg_start) begin
                    // Abort and restart; config_out is untouched.
                    shift_d = '0;
                    cnt_d   = '0;
`ifdef SWITCHBOX_CONFIG_PARITY_EN
                    par_d   = 1'b0;
`endif
                end else if (cfg_bit_valid) begin
                    // First bit accepted ends up in bit 0 after the full word.
                    shift_d = {cfg_bit_in, shift_q[CONFIG_WIDTH-1:1]};
`ifdef SWITCHBOX_CONFIG_PARITY_EN
                    par_d   = par_q ^ cfg_bit_in;
`endif
                    if (cnt_q == LAST_CNT) begin
                        // Wrap to 0 so the counter never exceeds CONFIG_WIDTH-1.
                        cnt_d = '0;
`ifdef SWITCHBOX_CONFIG_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = COMMIT;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
`ifdef SWITCHBOX_CONFIG_PARITY_EN
            PARITY: begin
                if (cfg_start) begin
                    shift_d = '0;
                    cnt_d   = '0;
                    par_d   = 1'b0;
                    state_d = SHIFT;
                end else if (cfg_bit_valid) begin
                    if (cfg_bit_in == par_q) begin
                        state_d = COMMIT;
                    end else begin
                        err_set = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
`endif
            COMMIT: begin
                // Start and valid are both ignored; the commit always completes.
                commit  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            config_out <= '0;
            cfg_busy   <= 1'b0;
            cfg_done   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            cfg_busy <= (state_d != IDLE);
            cfg_done <= commit;
            if (commit) begin
                config_out <= shift_q;
            end
        end
    end

`ifdef SWITCHBOX_CONFIG_PARITY_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            par_q     <= 1'b0;
            cfg_error <= 1'b0;
        end else begin
            par_q <= par_d;
            if (cfg_start) begin
                cfg_error <= 1'b0;
            end else if (err_set) begin
                cfg_error <= 1'b1;
            end
        end
    end
`else
    assign cfg_error = 1'b0;
`endif

endmodule

// File: doc/switchbox_config_loader.md
# switchbox_config_loader

Serial configuration loader that sits directly upstream of the switch box and drives its 264-bit `config_in` bus. It accepts a bit stream under a valid strobe, assembles it in a shift register, and atomically commits the completed word to a shadow register. Routing therefore never sees a partially loaded configuration. One instance sits per tile, fed by the device configuration controller.

## Interface
- `CONFIG_WIDTH`, default 264: payload bits; must match the switch box config width.
- `CNT_WIDTH`, default `$clog2(CONFIG_WIDTH)`: width of the bit counter.

Ports:
- `clock` input 1: single clock; all logic samples on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `cfg_start` input 1: single-cycle pulse that begins or restarts a load.
- `cfg_bit_in` input 1: serial config bit.
- `cfg_bit_valid` input 1: `cfg_bit_in` is valid this cycle.
- `config_out` output `CONFIG_WIDTH`: committed configuration, connected to the switch box `config_in`.
- `cfg_busy` output 1: a load is in progress.
- `cfg_done` output 1: one-cycle pulse when a commit completes.
- `cfg_error` output 1: sticky flag for a parity failure (only with the macro).

## Operation
- States: IDLE, SHIFT, PARITY (macro only), COMMIT.
- IDLE:
  - `cfg_start` clears the shift register and counter, then enters SHIFT.
  - `cfg_bit_valid` is ignored.
  - If `cfg_start` and `cfg_bit_valid` arrive in the same cycle, the start is taken and the bit is dropped.
- SHIFT:
  - Each cycle with `cfg_bit_valid`=1 does `shift <= {cfg_bit_in, shift[CONFIG_WIDTH-1:1]}` and increments the counter.
  - The first bit accepted lands in `config_out[0]`; the last lands in `config_out[CONFIG_WIDTH-1]`.
  - Cycles with valid=0 hold all state. Gaps are unlimited.
  - When the bit accepted has counter == `CONFIG_WIDTH-1`, the next state is PARITY if the macro is defined, otherwise COMMIT.
- PARITY: the next valid bit is compared with the XOR of all payload bits (even parity).
  - Match: go to COMMIT.
  - Mismatch: set `cfg_error` and return to IDLE. `config_out` is unchanged.
- COMMIT: `config_out <= shift`, `cfg_done` pulses, and the state returns to IDLE. `cfg_bit_valid` is ignored in this cycle.
- `cfg_start` in SHIFT or PARITY aborts and restarts: the shift register and counter clear, the state stays SHIFT, `config_out` is unchanged, and no `cfg_done` is produced. `cfg_start` in COMMIT is ignored; the commit still completes.
- `cfg_error` clears on `cfg_start` or `reset`.
- Counter arithmetic is unsigned, `CNT_WIDTH` bits, and never exceeds `CONFIG_WIDTH-1`.

## Timing
- Reset values:
  - `config_out` = 0, so every switch-box mux selects input 0.
  - `cfg_busy` = 0, `cfg_done` = 0, `cfg_error` = 0.
  - State is IDLE; the shift register and counter are 0.
- Reset has priority over every other input, including mid-load. A load interrupted by reset is discarded.
- `cfg_busy` is registered. It is high in every cycle that follows a state update into SHIFT, PARITY or COMMIT.
- Latency (no macro): the last payload bit is accepted at edge N. At edge N+1, `config_out` updates and `cfg_done` goes high for exactly one cycle. `cfg_busy` falls at edge N+1.
- With the macro, latency is measured from the edge at which the parity bit is accepted.
- Minimum load time: `CONFIG_WIDTH`+1 cycles without the macro, +2 cycles with it.
- `config_out` changes only at the COMMIT edge, with all bits updating on the same edge.

## Configuration
- `SWITCHBOX_CONFIG_PARITY_EN` defined:
  - The PARITY state and a running XOR register are compiled in.
  - One trailing parity bit is required per load.
  - `cfg_error` is functional.
- Not defined:
  - No PARITY state is built.
  - The load commits directly after `CONFIG_WIDTH` bits.
  - `cfg_error` is tied to 0.

## Test plan
- Reset: assert `reset` for 2 cycles with random inputs. Required: `config_out`=0, `cfg_busy`=0, `cfg_done`=0, `cfg_error`=0.
- Full load, no macro:
  - Stimulus: `cfg_start`, then 264 bits with bit0=1, bit1=0, bit2=1 and the rest 0.
  - Required: `config_out`=264'h5, `cfg_done` high for exactly 1 cycle at N+1, `config_out` stable before that edge.
- Valid gaps: the same stream as the full-load case with valid=0 inserted after every third bit. Required: identical `config_out`; `cfg_busy` high throughout.
- Abort and restart: start a load, send 100 bits, pulse `cfg_start`, then send 264 bits of all 1s. Required: `config_out` = all 1s, one `cfg_done`, no intermediate commit.
- Idle filtering: with `config_out`=264'h5, drive valid=1 for 10 cycles in IDLE, including one cycle where `cfg_start` is also high. Required: no change except that the start begins a load and the bit in the start cycle is dropped.
- Parity (macro defined):
  - Payload 264'h5 (XOR=0) with parity bit 1: required `cfg_error`=1, `config_out` unchanged, no `cfg_done`.
  - Resend the same payload with parity bit 0: required `cfg_error` cleared by the start pulse, commit succeeds.
